// File: rtl/adc_stream_arbiter_pkg.sv
// Shared types and constants for the dual-ADC stream arbiter.
// State encodings, source tags and the round-robin pick.
package adc_stream_arbiter_pkg;

  localparam int DATA_W = 16;

  localparam logic SRC_ADC1 = 1'b0;
  localparam logic SRC_ADC2 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Both pending: the source not granted last wins.
  function automatic logic rr_pick(
    input logic ne1,
    input logic ne2,
    input logic last
  );
    if (ne1 && ne2) return ~last;
    else if (ne1)   return SRC_ADC1;
    else            return SRC_ADC2;
  endfunction

endpackage

// File: rtl/adc_stream_arbiter_if.sv
// Per-source sample FIFO port bundle.
// master = arbiter side, slave = FIFO side.
interface adc_stream_arbiter_if;
  import adc_stream_arbiter_pkg::*;

  logic              push;
  logic [DATA_W-1:0] wdata;
  logic              pop;
  logic              flush;
  logic              full;
  logic              empty;
  logic              drop;
  logic [DATA_W-1:0] head;

  modport master (
    output push, wdata, pop, flush,
    input  full, empty, drop, head
  );

  modport slave (
    input  push, wdata, pop, flush,
    output full, empty, drop, head
  );

endinterface

// File: rtl/adc_stream_arbiter_sample_fifo.sv
// Per-source sample FIFO with flush and drop-on-full.
// A push into a full FIFO is kept if the same clock pops.
module sample_fifo
  import adc_stream_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic           i_clk,
  input logic           i_rst_n,
  adc_stream_arbiter_if.slave f
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q;
  logic [AW-1:0]     rd_q;
  logic [AW:0]       cnt_q;
  logic [AW:0]       cnt_d;
  logic              do_push;
  logic              do_pop;

  assign f.full  = (cnt_q == (AW+1)'(DEPTH));
  assign f.empty = (cnt_q == '0);
  assign f.head  = mem_q[rd_q];

  assign do_pop  = f.pop & ~f.empty & ~f.flush;
  assign do_push = f.push & ~f.flush & (~f.full | do_pop);
  assign f.drop  = f.push & ~f.flush & f.full & ~do_pop;

  assign cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

  // Pointer/count update; flush beats any push or pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (f.flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Sample storage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_q] <= f.wdata;
    end
  end

endmodule

// File: rtl/adc_stream_arbiter.sv
// Merges two ADC sample streams into one paced
// writer stream with round-robin source selection.
module adc_stream_arbiter
  import adc_stream_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CLK    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en_1,
  input  logic        i_en_2,
  input  logic        i_rx_dv_1,
  input  logic        i_rx_dv_2,
  input  logic [15:0] i_adc_data_1,
  input  logic [15:0] i_adc_data_2,
  input  logic        i_sink_ready,
  input  logic        i_txe_n,
  input  logic        i_clr_ovf,
  output logic        o_rx_dv,
  output logic [15:0] o_adc_data,
  output logic        o_src,
  output logic        o_ovf_1,
  output logic        o_ovf_2
);

  adc_stream_arbiter_if f1 ();
  adc_stream_arbiter_if f2 ();

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q;
  logic [7:0]  gap_q, gap_d;
  logic        fire;
  logic        sel_empty;
  logic        sel_flush;
  logic        rx_dv_q;
  logic [15:0] data_q;
  logic        src_q;
  logic        ovf1_q, ovf2_q;

  assign f1.push  = i_rx_dv_1 & i_en_1;
  assign f1.wdata = i_adc_data_1;
  assign f1.flush = ~i_en_1;
  assign f1.pop   = fire & (grant_q == SRC_ADC1);

  assign f2.push  = i_rx_dv_2 & i_en_2;
  assign f2.wdata = i_adc_data_2;
  assign f2.flush = ~i_en_2;
  assign f2.pop   = fire & (grant_q == SRC_ADC2);

  sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_1 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .f       (f1.slave)
  );

  sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_2 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .f       (f2.slave)
  );

  assign sel_empty = grant_q ? f2.empty : f1.empty;
  assign sel_flush = grant_q ? f2.flush : f1.flush;

  // Next state, grant and gap count. The IDLE clock is
  // the last idle clock of a gap, so GAP lasts
  // GAP_CLK-1 clocks (at least one).
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gap_d   = gap_q;
    fire    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        gap_d = '0;
        if ((!f1.empty || !f2.empty) &&
            i_sink_ready && !i_txe_n) begin
          state_d = ST_ISSUE;
          grant_d = rr_pick(!f1.empty, !f2.empty,
                            last_q);
        end
      end
      ST_ISSUE: begin
        gap_d = '0;
        if (sel_flush || sel_empty) begin
          state_d = ST_IDLE;
        end else begin
          fire    = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (32'(gap_q) + 32'd2 >= 32'(GAP_CLK)) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gap_d   = '0;
      end
    endcase
  end

  // FSM and arbitration registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= SRC_ADC1;
      last_q  <= SRC_ADC2;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gap_q   <= gap_d;
      if (fire) last_q <= grant_q;
    end
  end

  // Output stream; data and tag hold between strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_dv_q <= 1'b0;
      data_q  <= '0;
      src_q   <= SRC_ADC1;
    end else begin
      rx_dv_q <= fire;
      if (fire) begin
        data_q <= grant_q ? f2.head : f1.head;
        src_q  <= grant_q;
      end
    end
  end

  // Sticky overflow flags; a new drop beats clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf1_q <= 1'b0;
      ovf2_q <= 1'b0;
    end else begin
      if (f1.drop)       ovf1_q <= 1'b1;
      else if (i_clr_ovf) ovf1_q <= 1'b0;
      if (f2.drop)       ovf2_q <= 1'b1;
      else if (i_clr_ovf) ovf2_q <= 1'b0;
    end
  end

  assign o_rx_dv    = rx_dv_q;
  assign o_adc_data = data_q;
  assign o_src      = src_q;
  assign o_ovf_1    = ovf1_q;
  assign o_ovf_2    = ovf2_q;

endmodule

// File: tb/tb_adc_stream_arbiter.sv
// Bench for adc_stream_arbiter: vector table plus
// scoreboard of expected output samples.
module tb_adc_stream_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_1, en_2;
  logic        dv_1, dv_2;
  logic [15:0] d_1, d_2;
  logic        sink_ready, txe_n, clr_ovf;
  logic        rx_dv;
  logic [15:0] adc_data;
  logic        src;
  logic        ovf_1, ovf_2;

  // Bundle of the first source's FIFO-facing signals,
  // mirrored from the bench drive for waveform grouping.
  adc_stream_arbiter_if mon_if ();
  assign mon_if.push  = dv_1 & en_1;
  assign mon_if.wdata = d_1;
  assign mon_if.pop   = 1'b0;
  assign mon_if.flush = ~en_1;
  assign mon_if.full  = 1'b0;
  assign mon_if.empty = 1'b0;
  assign mon_if.drop  = 1'b0;
  assign mon_if.head  = '0;

  adc_stream_arbiter #(.FIFO_DEPTH(4), .GAP_CLK(2)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en_1       (en_1),
    .i_en_2       (en_2),
    .i_rx_dv_1    (dv_1),
    .i_rx_dv_2    (dv_2),
    .i_adc_data_1 (d_1),
    .i_adc_data_2 (d_2),
    .i_sink_ready (sink_ready),
    .i_txe_n      (txe_n),
    .i_clr_ovf    (clr_ovf),
    .o_rx_dv      (rx_dv),
    .o_adc_data   (adc_data),
    .o_src        (src),
    .o_ovf_1      (ovf_1),
    .o_ovf_2      (ovf_2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [15:0] d;
  } exp_t;

  typedef struct {
    logic        dv1, dv2;
    logic [15:0] d1, d2;
    int          nout;
    logic        s0;
    logic [15:0] e0;
    logic        s1;
    logic [15:0] e1;
  } vec_t;

  exp_t exp_q[$];
  int   st_cyc[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[5];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               nm, act, req, cyc);
    end
  endtask

  // Scoreboard: every strobe must match the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rx_dv === 1'b1) begin
      st_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got %0h src %0d want none",
                 adc_data, src);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("strobe_src", 32'(src), 32'(e.s));
        chk("strobe_data", 32'(adc_data), 32'(e.d));
      end
    end
  end

  // Present strobes for one clock; n = capturing edge.
  task automatic drive(input logic s1, input logic s2,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       output int n);
    @(posedge clk);
    #1;
    dv_1 = s1; dv_2 = s2; d_1 = a; d_2 = b;
    @(posedge clk);
    #1;
    n = cyc;
    dv_1 = 1'b0; dv_2 = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_strobes(input int target,
                              input int budget);
    int k = 0;
    while (st_cyc.size() < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    #1;
    chk("strobe_count", 32'(st_cyc.size()), 32'(target));
  endtask

  task automatic no_strobe(input string nm,
                           input int k);
    int base;
    base = st_cyc.size();
    idle(k);
    chk(nm, 32'(st_cyc.size()), 32'(base));
  endtask

  initial begin
    int n, base, t;

    tbl[0] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 1,
               1'b0, 16'h1234, 1'b0, 16'h0000};
    tbl[1] = '{1'b0, 1'b1, 16'h0000, 16'h5678, 1,
               1'b1, 16'h5678, 1'b0, 16'h0000};
    tbl[2] = '{1'b1, 1'b1, 16'hAAAA, 16'hBBBB, 2,
               1'b0, 16'hAAAA, 1'b1, 16'hBBBB};
    tbl[3] = '{1'b1, 1'b0, 16'h0F0F, 16'h0000, 1,
               1'b0, 16'h0F0F, 1'b0, 16'h0000};
    tbl[4] = '{1'b1, 1'b1, 16'hC1C1, 16'hC2C2, 2,
               1'b1, 16'hC2C2, 1'b0, 16'hC1C1};

    rst_n = 1'b0;
    en_1 = 1'b1; en_2 = 1'b1;
    dv_1 = 1'b0; dv_2 = 1'b0;
    d_1 = '0; d_2 = '0;
    sink_ready = 1'b1; txe_n = 1'b0; clr_ovf = 1'b0;
    idle(3);
    chk("rst_dv", 32'(rx_dv), 0);
    chk("rst_data", 32'(adc_data), 0);
    chk("rst_src", 32'(src), 0);
    chk("rst_ovf1", 32'(ovf_1), 0);
    chk("rst_ovf2", 32'(ovf_2), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Table: single sources and contention.
    for (int i = 0; i < 5; i++) begin
      base = st_cyc.size();
      exp_q.push_back('{tbl[i].s0, tbl[i].e0});
      if (tbl[i].nout == 2)
        exp_q.push_back('{tbl[i].s1, tbl[i].e1});
      drive(tbl[i].dv1, tbl[i].dv2,
            tbl[i].d1, tbl[i].d2, n);
      wait_strobes(base + tbl[i].nout, 20);
      if (st_cyc.size() > base)
        chk("lat_first", 32'(st_cyc[base] - n), 2);
      if (tbl[i].nout == 2 && st_cyc.size() > base + 1)
        chk("lat_second", 32'(st_cyc[base+1] - n), 5);
      idle(6);
    end

    // Overflow on ADC2 with the sink stalled.
    sink_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back('{1'b1, 16'h2000 + 16'(i)});
      drive(1'b0, 1'b1, 16'h0, 16'h2000 + 16'(i), n);
    end
    chk("ovf2_set", 32'(ovf_2), 1);
    chk("ovf1_clear", 32'(ovf_1), 0);
    no_strobe("stalled_no_strobe", 4);
    base = st_cyc.size();
    sink_ready = 1'b1;
    wait_strobes(base + 4, 30);
    if (st_cyc.size() >= base + 4)
      chk("ovf_spacing", 32'(st_cyc[base+3] - st_cyc[base]), 9);
    chk("ovf2_sticky", 32'(ovf_2), 1);
    @(posedge clk); #1; clr_ovf = 1'b1;
    @(posedge clk); #1; clr_ovf = 1'b0;
    chk("ovf2_cleared", 32'(ovf_2), 0);

    // Drop coincident with clear: the drop wins.
    sink_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      drive(1'b0, 1'b1, 16'h0, 16'h2100 + 16'(i), n);
    @(posedge clk); #1;
    dv_2 = 1'b1; d_2 = 16'h2104; clr_ovf = 1'b1;
    @(posedge clk); #1;
    dv_2 = 1'b0; clr_ovf = 1'b0;
    chk("ovf2_drop_beats_clr", 32'(ovf_2), 1);
    @(posedge clk); #1; en_2 = 1'b0;
    @(posedge clk); #1; en_2 = 1'b1;
    sink_ready = 1'b1;
    no_strobe("flush2_no_strobe", 10);

    // Backpressure from the FT232H TX FIFO.
    txe_n = 1'b1;
    exp_q.push_back('{1'b0, 16'h3001});
    exp_q.push_back('{1'b0, 16'h3002});
    drive(1'b1, 1'b0, 16'h3001, 16'h0, n);
    drive(1'b1, 1'b0, 16'h3002, 16'h0, n);
    no_strobe("txe_no_strobe", 8);
    base = st_cyc.size();
    txe_n = 1'b0;
    t = cyc;
    wait_strobes(base + 2, 20);
    if (st_cyc.size() >= base + 2) begin
      chk("txe_resume_lat", 32'(st_cyc[base] - t), 2);
      chk("txe_spacing", 32'(st_cyc[base+1] - st_cyc[base]), 3);
    end
    idle(4);

    // Flush ADC1 with three samples queued.
    sink_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'b0, 16'h6000 + 16'(i), 16'h0, n);
    @(posedge clk); #1; en_1 = 1'b0;
    @(posedge clk); #1; en_1 = 1'b1;
    sink_ready = 1'b1;
    no_strobe("flush1_no_strobe", 10);

    // Reset asserted while the FSM is in ISSUE.
    exp_q.push_back('{1'b0, 16'h4444});
    drive(1'b1, 1'b0, 16'h4444, 16'h0, n);
    @(posedge clk);
    #1;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    chk("midrst_dv", 32'(rx_dv), 0);
    chk("midrst_data", 32'(adc_data), 0);
    chk("midrst_src", 32'(src), 0);
    @(negedge clk);
    rst_n = 1'b1;
    no_strobe("postrst_no_strobe", 10);

    // Normal service after reset.
    base = st_cyc.size();
    exp_q.push_back('{1'b1, 16'h5555});
    drive(1'b0, 1'b1, 16'h0, 16'h5555, n);
    wait_strobes(base + 1, 20);
    if (st_cyc.size() > base)
      chk("postrst_lat", 32'(st_cyc[base] - n), 2);
    idle(4);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
